ap_result_packer: RTL and testbench
===================================

Name: ap_result_packer

Overview:
- Upstream feeder of the AP_total wide-word memory in the CG datapath.
- Accepts scalar A·p results one element per handshake from the matrix-vector unit.
- Packs NO_OF_UNITS elements into one wide word, zero-pads the final partial word, and generates the write address and write-enable for the memory.
- Signals completion of one vector pass with a single-cycle done pulse.

Parameters:
ELEMENT_WIDTH, 64, width of one scalar result
NO_OF_UNITS, 8, lanes per memory word
NUMBER_OF_EQUATIONS, 9, elements per vector pass (N), must be >= 1
ADDRESS_WIDTH, 32, width of mem_address, matching the memory's 32-bit address port
BASE_ADDRESS, 0, first memory word address of a pass

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a pass; sampled only in IDLE
in_data  in  ELEMENT_WIDTH  scalar result
in_valid  in  1  in_data valid
in_ready  out  1  packer accepts in_data this cycle
mem_data  out  ELEMENT_WIDTH*NO_OF_UNITS  packed word to memory input_data
mem_address  out  ADDRESS_WIDTH  word address to memory address
mem_write_enable  out  1  one-cycle write strobe
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the last word is written

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; counters 0; lane buffer 0.
- States:
  - IDLE: start=1 moves to COLLECT. elem_cnt, lane_cnt and addr_cnt load 0, 0 and BASE_ADDRESS; lane buffer clears.
  - COLLECT: in_ready=1. Each accept (in_valid & in_ready) writes in_data into lane lane_cnt. Lane 0 occupies bits [ELEMENT_WIDTH-1:0]. lane_cnt and elem_cnt then increment.
  - Word completion: occurs when the accepted element fills lane NO_OF_UNITS-1 or is element N-1. On the next cycle:
    - mem_write_enable=1, mem_data=buffer with unfilled lanes 0, mem_address=addr_cnt.
    - addr_cnt then increments. lane_cnt returns to 0 and the buffer clears for the next word.
  - After element N-1 is accepted, the state moves to FLUSH. in_ready=0 from the next cycle.
  - FLUSH: lasts one cycle, the cycle carrying the final write. Then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Word count and address range:
  - Words written = ceil(N/NO_OF_UNITS).
  - Addresses run BASE_ADDRESS .. BASE_ADDRESS+words-1.
- Throughput: one element per cycle. Collection of the next word overlaps the registered write of the previous word. The memory never back-pressures.
- Latency: element accept to write strobe is 1 cycle. Final write to done is 1 cycle.
- Boundary conditions:
  - start while not IDLE: ignored.
  - in_valid outside COLLECT: ignored; in_ready=0.
  - in_valid=0 gaps: no state change.
  - N multiple of NO_OF_UNITS: no padding word is emitted.
  - addr_cnt wraps modulo 2^ADDRESS_WIDTH.
  - rst_n low mid-pass: immediate return to reset values. A partially packed word is discarded and not written.
- Output timing: mem_data and mem_address hold their last values when mem_write_enable=0 and are don't-care to the memory. busy=0 in IDLE.

Optional Feature:
- Macro: AP_PACKER_OVERRUN_EN.
- When defined:
  - Adds output overrun (1 bit, reset 0).
  - overrun sets sticky when in_valid=1 while state is not COLLECT and busy=1, i.e. the producer sends more than N elements.
  - overrun clears only on rst_n or on an accepted start.
- When undefined: the port is absent and extra in_valid pulses are silently ignored.

Decomposition:
- Shared package cg_pkg holds:
  - State enum {IDLE, COLLECT, FLUSH, DONE}.
  - Constant function ceil_div(N,U) for word count.
  - Lane width constant derived from ELEMENT_WIDTH*NO_OF_UNITS.
- One natural sub-module, ap_lane_buffer:
  - Lane-indexed register bank with write-by-index, clear and zero-padded output.
  - The FSM and counters stay in ap_result_packer.

Test Plan:
- N=9, U=8, BASE=0, values 1..9 back-to-back → write addr0 lanes0-7 = 1..8; write addr1 lane0 = 9, lanes1-7 = 0; done one cycle after second write; exactly 2 strobes.
- N=16, U=8, values 0x10..0x1F with random in_valid gaps → two writes at addr0 and addr1 with no padding word; done once; in_ready=0 after 16th accept.
- BASE_ADDRESS=100, N=9 → writes at 100 and 101; second pass started after done → writes again at 100 and 101.
- start pulsed during COLLECT after 3 elements → ignored; pass completes normally with the correct 2 words.
- rst_n asserted after 5 elements → all outputs 0 immediately and no write issued; new start then 9 elements → correct 2 writes.
- AP_PACKER_OVERRUN_EN defined, 10 in_valid pulses for N=9 → 10th pulse sets overrun=1 and writes are unchanged; next start clears overrun.

Source files
------------

// File: rtl/cg_pkg.sv
// ---------------------------------------------------------------------------
// cg_pkg: shared types and constants for the CG datapath result packer.
//   state_t          : packer FSM states
//   ceil_div()       : word count for N elements packed U per word
//   *_DEF            : default element width / lanes per word
//   LANE_WIDTH       : default packed word width (ELEMENT_WIDTH*NO_OF_UNITS)
// ---------------------------------------------------------------------------
package cg_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FLUSH   = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int ELEMENT_WIDTH_DEF = 64;
   localparam int NO_OF_UNITS_DEF   = 8;
   localparam int LANE_WIDTH        = ELEMENT_WIDTH_DEF * NO_OF_UNITS_DEF;

   function automatic int ceil_div(input int n, input int u);
      return (n + u - 1) / u;
   endfunction

endpackage

// File: rtl/ap_lane_buffer.sv
// ---------------------------------------------------------------------------
// ap_lane_buffer: lane-indexed register bank used to assemble one wide word.
//   clk, rst_n : clock, async active-low reset (bank clears)
//   clr        : clear every lane on this edge (wins over wr_en)
//   wr_en      : write wr_data into lane wr_idx on this edge
//   wr_idx     : target lane
//   wr_data    : element to store
//   word       : current contents with this cycle's write already merged in,
//                so the word that is completing can be captured the same
//                cycle its last lane arrives. Unwritten lanes read as 0.
// ---------------------------------------------------------------------------
module ap_lane_buffer
   import cg_pkg::*;
#(
   parameter int ELEMENT_WIDTH = ELEMENT_WIDTH_DEF,
   parameter int NO_OF_UNITS   = NO_OF_UNITS_DEF,
   parameter int IDX_W         = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 clr,
   input  logic                                 wr_en,
   input  logic [IDX_W-1:0]                     wr_idx,
   input  logic [ELEMENT_WIDTH-1:0]             wr_data,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] word
);

   logic [NO_OF_UNITS-1:0][ELEMENT_WIDTH-1:0] lanes;
   logic [NO_OF_UNITS-1:0][ELEMENT_WIDTH-1:0] merged;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes <= '0;
      end else if (clr) begin
         lanes <= '0;
      end else if (wr_en) begin
         for (int l = 0; l < NO_OF_UNITS; l++)
            if (wr_idx == IDX_W'(l)) lanes[l] <= wr_data;
      end
   end

   always_comb begin
      merged = lanes;
      for (int l = 0; l < NO_OF_UNITS; l++)
         if (wr_en && (wr_idx == IDX_W'(l))) merged[l] = wr_data;
   end

   assign word = merged;

endmodule

// File: rtl/ap_result_packer.sv
// ---------------------------------------------------------------------------
// ap_result_packer: packs scalar A.p results NO_OF_UNITS per wide word and
// writes them to the AP_total memory, zero-padding the final partial word.
//   clk, rst_n        : clock, async active-low reset
//   start             : begin a pass (sampled only in IDLE)
//   in_data/in_valid  : scalar result stream
//   in_ready          : high in COLLECT only
//   mem_data          : packed word, lane 0 in the LSBs
//   mem_address       : word address, BASE_ADDRESS upward, wraps
//   mem_write_enable  : one-cycle strobe, the cycle after a word completes
//   busy              : high in every state but IDLE
//   done              : one-cycle pulse the cycle after the final write
//   overrun           : (AP_PACKER_OVERRUN_EN only) sticky flag, set when
//                       in_valid arrives while busy but no longer collecting;
//                       cleared by reset or an accepted start
// Optional feature macro: AP_PACKER_OVERRUN_EN
// ---------------------------------------------------------------------------
module ap_result_packer
   import cg_pkg::*;
#(
   parameter int                   ELEMENT_WIDTH       = ELEMENT_WIDTH_DEF,
   parameter int                   NO_OF_UNITS         = NO_OF_UNITS_DEF,
   parameter int                   NUMBER_OF_EQUATIONS = 9,
   parameter int                   ADDRESS_WIDTH       = 32,
   parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS    = '0
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 start,
   input  logic [ELEMENT_WIDTH-1:0]             in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] mem_data,
   output logic [ADDRESS_WIDTH-1:0]             mem_address,
   output logic                                 mem_write_enable,
   output logic                                 busy,
   output logic                                 done
`ifdef AP_PACKER_OVERRUN_EN
   ,
   output logic                                 overrun
`endif
);

   localparam int WORD_W = ELEMENT_WIDTH * NO_OF_UNITS;
   localparam int LANE_W = (NO_OF_UNITS > 1) ? $clog2(NO_OF_UNITS) : 1;
   localparam int CNT_W  = $clog2(NUMBER_OF_EQUATIONS + 1);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   elem_cnt;
   logic [LANE_W-1:0]  lane_cnt;
   logic [ADDRESS_WIDTH-1:0] addr_cnt;
   logic [WORD_W-1:0]  buf_word;

   logic start_acc, accept, last_elem, lane_full, word_done;

   assign in_ready  = (state == COLLECT);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign start_acc = (state == IDLE) && start;
   assign accept    = in_valid && in_ready;
   assign last_elem = (elem_cnt == CNT_W'(NUMBER_OF_EQUATIONS - 1));
   assign lane_full = (lane_cnt == LANE_W'(NO_OF_UNITS - 1));
   assign word_done = accept && (last_elem || lane_full);

   // Buffer clears on start and on every completed word; the completing
   // element is taken from the merged view, so clear may win over the write.
   ap_lane_buffer #(
      .ELEMENT_WIDTH (ELEMENT_WIDTH),
      .NO_OF_UNITS   (NO_OF_UNITS),
      .IDX_W         (LANE_W)
   ) u_lane_buffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (start_acc || word_done),
      .wr_en   (accept),
      .wr_idx  (lane_cnt),
      .wr_data (in_data),
      .word    (buf_word)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = COLLECT;
         COLLECT: if (accept && last_elem) state_nxt = FLUSH;
         FLUSH:   state_nxt = DONE;   // final write strobe is on the bus
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- counters and write port ----------------
   // The write is registered off the completing accept, so collection of the
   // next word proceeds in the same cycle the previous word is strobed out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_cnt         <= '0;
         lane_cnt         <= '0;
         addr_cnt         <= '0;
         mem_data         <= '0;
         mem_address      <= '0;
         mem_write_enable <= 1'b0;
      end else begin
         mem_write_enable <= word_done;
         if (start_acc) begin
            elem_cnt <= '0;
            lane_cnt <= '0;
            addr_cnt <= BASE_ADDRESS;
         end else if (accept) begin
            elem_cnt <= elem_cnt + CNT_W'(1);
            lane_cnt <= word_done ? '0 : lane_cnt + LANE_W'(1);
         end
         if (word_done) begin
            mem_data    <= buf_word;
            mem_address <= addr_cnt;
            addr_cnt    <= addr_cnt + ADDRESS_WIDTH'(1);
         end
      end
   end

`ifdef AP_PACKER_OVERRUN_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   overrun <= 1'b0;
      else if (start_acc)                           overrun <= 1'b0;
      else if (in_valid && busy && state != COLLECT) overrun <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_ap_result_packer.sv
// ---------------------------------------------------------------------------
// Bench for ap_result_packer. Three instances share clk/rst_n:
//   0: N=9,  BASE=0      1: N=16, BASE=0      2: N=9, BASE=100
// Expected words are rebuilt from the list of accepted elements: word w holds
// elements w*U .. w*U+U-1 (lane 0 in the LSBs), missing ones read as zero.
// ---------------------------------------------------------------------------
module tb_ap_result_packer;
   import cg_pkg::*;

   localparam int EW = 64;
   localparam int U  = 8;
   localparam int AW = 32;
   localparam int NI = 3;
   localparam int WW = EW * U;

   function automatic int n_of(input int i);
      return (i == 1) ? 16 : 9;
   endfunction
   function automatic int base_of(input int i);
      return (i == 2) ? 100 : 0;
   endfunction

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          start    [NI];
   logic          in_valid [NI];
   logic [EW-1:0] in_data  [NI];
   logic          in_ready [NI];
   logic [WW-1:0] mem_data [NI];
   logic [AW-1:0] mem_address [NI];
   logic          we   [NI];
   logic          busy [NI];
   logic          done [NI];
`ifdef AP_PACKER_OVERRUN_EN
   logic          overrun [NI];
`endif

   for (genvar g = 0; g < NI; g++) begin : g_dut
      ap_result_packer #(
         .ELEMENT_WIDTH       (EW),
         .NO_OF_UNITS         (U),
         .NUMBER_OF_EQUATIONS (n_of(g)),
         .ADDRESS_WIDTH       (AW),
         .BASE_ADDRESS        (AW'(base_of(g)))
      ) dut (
         .clk              (clk),
         .rst_n            (rst_n),
         .start            (start[g]),
         .in_data          (in_data[g]),
         .in_valid         (in_valid[g]),
         .in_ready         (in_ready[g]),
         .mem_data         (mem_data[g]),
         .mem_address      (mem_address[g]),
         .mem_write_enable (we[g]),
         .busy             (busy[g]),
         .done             (done[g])
`ifdef AP_PACKER_OVERRUN_EN
         ,
         .overrun          (overrun[g])
`endif
      );
   end

   int checks = 0;
   int failures = 0;

   function automatic void chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endfunction

   // ---------------- write / done monitor ----------------
   typedef struct {
      int            inst;
      logic [AW-1:0] addr;
      logic [WW-1:0] data;
   } wr_t;

   wr_t wq[$];
   int  done_cnt [NI];
   logic prev_we [NI];

   initial for (int i = 0; i < NI; i++) begin done_cnt[i] = 0; prev_we[i] = 1'b0; end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (we[i] === 1'b1) wq.push_back('{i, mem_address[i], mem_data[i]});
         if (done[i] === 1'b1) begin
            done_cnt[i]++;
            chk("done_after_final_write", prev_we[i], 1'b1);
         end
         prev_we[i] = we[i];
      end
   end

   // ---------------- reference model ----------------
   logic [EW-1:0] exp_el[$];

   function automatic logic [WW-1:0] model_word(input int w);
      logic [WW-1:0] r;
      r = '0;
      for (int l = 0; l < U; l++)
         if (w * U + l < exp_el.size()) r[l*EW +: EW] = exp_el[w*U + l];
      return r;
   endfunction

   task automatic check_words(input int i, input int exp_words, input int addr0);
      int n;
      chk("word_count", WW'(wq.size()), WW'(exp_words));
      n = (wq.size() < exp_words) ? wq.size() : exp_words;
      for (int w = 0; w < n; w++) begin
         chk("wr_inst", WW'(wq[w].inst), WW'(i));
         chk("wr_addr", WW'(wq[w].addr), WW'(AW'(addr0 + w)));
         chk("wr_data", wq[w].data, model_word(w));
      end
      wq.delete();
   endtask

   // Drives one pass on instance i: nsend valid pulses (gaps optional),
   // optional stray start at element start_at, optional abort after stop_at
   // accepts (returns without waiting for done).
   task automatic run_pass(input int i, input int nsend, input bit gaps, input bit rnd,
                           input logic [EW-1:0] v0, input int start_at, input int stop_at);
      int sent, guard, t, d0;
      logic rdy;
      exp_el.delete();
      d0 = done_cnt[i];
      @(posedge clk); #1 start[i] = 1'b1;
      @(posedge clk); #1 start[i] = 1'b0;
      chk("busy_after_start", busy[i], 1'b1);
      sent = 0; guard = 0;
      while (sent < nsend && guard < 2000) begin
         if (stop_at >= 0 && exp_el.size() == stop_at) break;
         start[i] = (sent == start_at);
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid[i] = 1'b0;
         end else begin
            in_valid[i] = 1'b1;
            in_data[i]  = rnd ? {$urandom, $urandom} : v0 + EW'(sent);
         end
         rdy = in_ready[i];
         @(posedge clk); #1;
         if (in_valid[i]) begin
            sent++;
            if (rdy) exp_el.push_back(in_data[i]);
         end
         guard++;
      end
      in_valid[i] = 1'b0;
      start[i] = 1'b0;
      if (guard >= 2000) chk("drive_timeout", 1'b1, 1'b0);
      if (stop_at >= 0) return;
      chk("accept_count", WW'(exp_el.size()), WW'((nsend < n_of(i)) ? nsend : n_of(i)));
      chk("in_ready_low_after_last", in_ready[i], 1'b0);
      t = 0;
      while (done[i] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      chk("done_seen", done[i], 1'b1);
      @(posedge clk); #1;
      chk("busy_low_after_done", busy[i], 1'b0);
      @(posedge clk); #1;
      chk("done_pulse_count", WW'(done_cnt[i] - d0), WW'(1));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int            inst;
      int            nsend;
      bit            gaps;
      bit            rnd;
      logic [EW-1:0] v0;
      int            exp_words;
      int            exp_addr0;
   } vec_t;

   vec_t vt[6];

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{0,  9, 1'b0, 1'b0, 64'd1,    2, 0};    // 1..9 back-to-back
      vt[1] = '{1, 16, 1'b1, 1'b0, 64'h10,   2, 0};    // exact fit, gaps
      vt[2] = '{2,  9, 1'b0, 1'b1, 64'd0,    2, 100};  // base 100
      vt[3] = '{2,  9, 1'b1, 1'b1, 64'd0,    2, 100};  // second pass, same addrs
      vt[4] = '{0,  9, 1'b1, 1'b1, 64'd0,    2, 0};
      vt[5] = '{1, 16, 1'b1, 1'b1, 64'd0,    2, 0};

      for (int i = 0; i < NI; i++) begin
         start[i] = 1'b0; in_valid[i] = 1'b0; in_data[i] = '0;
      end

      // reset state
      #12;
      for (int i = 0; i < NI; i++) begin
         chk("rst_in_ready", in_ready[i], 1'b0);
         chk("rst_we", we[i], 1'b0);
         chk("rst_busy", busy[i], 1'b0);
         chk("rst_done", done[i], 1'b0);
         chk("rst_mem_data", mem_data[i], '0);
         chk("rst_mem_address", WW'(mem_address[i]), '0);
`ifdef AP_PACKER_OVERRUN_EN
         chk("rst_overrun", overrun[i], 1'b0);
`endif
      end
      @(negedge clk) rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         run_pass(vt[v].inst, vt[v].nsend, vt[v].gaps, vt[v].rnd, vt[v].v0, -1, -1);
         check_words(vt[v].inst, vt[v].exp_words, vt[v].exp_addr0);
      end

      // stray start after 3 elements: ignored
      run_pass(0, 9, 1'b0, 1'b0, 64'h100, 3, -1);
      check_words(0, 2, 0);

      // reset mid-pass after 5 accepts: no write, outputs clear at once
      run_pass(0, 9, 1'b0, 1'b0, 64'h200, -1, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready[0], 1'b0);
      chk("midrst_busy", busy[0], 1'b0);
      chk("midrst_we", we[0], 1'b0);
      chk("midrst_mem_data", mem_data[0], '0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      chk("midrst_no_write", WW'(wq.size()), '0);
      wq.delete();
      run_pass(0, 9, 1'b0, 1'b0, 64'h300, -1, -1);
      check_words(0, 2, 0);

      // one extra valid pulse beyond N: writes unchanged
      run_pass(0, 10, 1'b0, 1'b0, 64'h400, -1, -1);
      check_words(0, 2, 0);
`ifdef AP_PACKER_OVERRUN_EN
      chk("overrun_set", overrun[0], 1'b1);
      run_pass(0, 9, 1'b0, 1'b0, 64'h500, -1, -1);
      chk("overrun_cleared_by_start", overrun[0], 1'b0);
      check_words(0, 2, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
